// File: rtl/pad_window_scanner_pkg.sv
// ============================================================================
// pad_window_scanner_pkg : shared sizes and FSM state type for the scanner
// Revision: 1.0
// ============================================================================
`default_nettype none

package pad_window_scanner_pkg;
    localparam int DATA_W   = 10;
    localparam int WIN_TAPS = 9;
    localparam int MAX_DIM  = 64;
    localparam int ADDR_W   = 12;
    localparam int DIM_W    = $clog2(MAX_DIM) + 1;
    localparam int COORD_W  = $clog2(MAX_DIM);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/pad_mask_calc.sv
// ============================================================================
// pad_mask_calc : 3x3 in-bounds mask for a window centred at (r, c)
// Revision: 1.0
// ============================================================================
`default_nettype none

module pad_mask_calc
    import pad_window_scanner_pkg::*;
(
    input  logic [COORD_W-1:0]  r,
    input  logic [COORD_W-1:0]  c,
    input  logic [DIM_W-1:0]    h,
    input  logic [DIM_W-1:0]    w,
    output logic [WIN_TAPS-1:0] sel
);
    logic [2:0] w_row_ok;
    logic [2:0] w_col_ok;

    // The centre is always inside the map, so only the outer taps need tests.
    assign w_row_ok[0] = (r != '0);
    assign w_row_ok[1] = 1'b1;
    assign w_row_ok[2] = (({1'b0, r} + DIM_W'(1)) < h);
    assign w_col_ok[0] = (c != '0);
    assign w_col_ok[1] = 1'b1;
    assign w_col_ok[2] = (({1'b0, c} + DIM_W'(1)) < w);

    for (genvar dr = 0; dr < 3; dr++) begin : g_row
        for (genvar dc = 0; dc < 3; dc++) begin : g_col
            assign sel[3*dr+dc] = w_row_ok[dr] & w_col_ok[dc];
        end
    end
endmodule

`default_nettype wire

// File: rtl/pad_window_scanner.sv
// ============================================================================
// pad_window_scanner : raster scan of 3x3 window centres with padding masks
// Revision: 1.0
// ============================================================================
`default_nettype none

module pad_window_scanner
    import pad_window_scanner_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [DIM_W-1:0]    i_height,
    input  logic [DIM_W-1:0]    i_width,
    input  logic                i_stride2,
    input  logic                i_ready,
    output logic                o_busy,
    output logic                o_valid,
    output logic [WIN_TAPS-1:0] o_sel,
    output logic [COORD_W-1:0]  o_row,
    output logic [COORD_W-1:0]  o_col,
    output logic [ADDR_W-1:0]   o_addr,
    output logic                o_last,
    output logic                o_done
);
    state_t              r_state;
    logic [DIM_W-1:0]    r_h;
    logic [DIM_W-1:0]    r_w;
    logic                r_s2;
    logic [COORD_W-1:0]  r_row;
    logic [COORD_W-1:0]  r_col;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_base;

    logic [DIM_W-1:0]    w_h;
    logic [DIM_W-1:0]    w_w;
    logic                w_s2;
    logic [1:0]          w_step;
    logic [DIM_W-1:0]    w_col_adv;
    logic [ADDR_W-1:0]   w_row_inc;
    logic [COORD_W-1:0]  w_nrow;
    logic [COORD_W-1:0]  w_ncol;
    logic [ADDR_W-1:0]   w_naddr;
    logic [ADDR_W-1:0]   w_nbase;
    logic                w_nlast;
    logic [WIN_TAPS-1:0] w_nsel;

    // In IDLE the next position is the frame origin under the incoming config.
    always_comb begin
        w_h       = (r_state == S_IDLE) ? i_height  : r_h;
        w_w       = (r_state == S_IDLE) ? i_width   : r_w;
        w_s2      = (r_state == S_IDLE) ? i_stride2 : r_s2;
        w_step    = w_s2 ? 2'd2 : 2'd1;
        w_col_adv = {1'b0, r_col} + DIM_W'(w_step);
        w_row_inc = w_s2 ? (ADDR_W'(w_w) << 1) : ADDR_W'(w_w);
        w_nrow    = '0;
        w_ncol    = '0;
        w_naddr   = '0;
        w_nbase   = '0;
        if (r_state != S_IDLE) begin
            if (w_col_adv < w_w) begin
                w_nrow  = r_row;
                w_ncol  = w_col_adv[COORD_W-1:0];
                w_naddr = r_addr + ADDR_W'(w_step);
                w_nbase = r_base;
            end else begin
                w_nrow  = r_row + COORD_W'(w_step);
                w_ncol  = '0;
                w_naddr = r_base + w_row_inc;
                w_nbase = r_base + w_row_inc;
            end
        end
        w_nlast = (({1'b0, w_ncol} + DIM_W'(w_step)) >= w_w) &&
                  (({1'b0, w_nrow} + DIM_W'(w_step)) >= w_h);
    end

    pad_mask_calc u_mask (
        .r   (w_nrow),
        .c   (w_ncol),
        .h   (w_h),
        .w   (w_w),
        .sel (w_nsel)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_w     <= '0;
            r_s2    <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_addr  <= '0;
            r_base  <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_sel   <= '0;
            o_last  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        o_busy <= 1'b1;
                        if (i_height != '0 && i_width != '0) begin
                            r_h     <= i_height;
                            r_w     <= i_width;
                            r_s2    <= i_stride2;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_addr  <= '0;
                            r_base  <= '0;
                            o_sel   <= w_nsel;
                            o_last  <= w_nlast;
                            o_valid <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (o_valid && i_ready) begin
                        if (o_last) begin
                            o_valid <= 1'b0;
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row  <= w_nrow;
                            r_col  <= w_ncol;
                            r_addr <= w_naddr;
                            r_base <= w_nbase;
                            o_sel  <= w_nsel;
                            o_last <= w_nlast;
                        end
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_addr = r_addr;
endmodule

`default_nettype wire

// File: tb/tb_pad_window_scanner.sv
// ============================================================================
// tb_pad_window_scanner : directed frames checked against a raster-scan model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pad_window_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  height = '0;
    logic [6:0]  width = '0;
    logic        stride2 = 1'b0;
    logic        ready = 1'b1;
    logic        busy, valid, last, done;
    logic [8:0]  sel;
    logic [5:0]  row, col;
    logic [11:0] addr;

    pad_window_scanner dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_height(height),
        .i_width(width), .i_stride2(stride2), .i_ready(ready), .o_busy(busy),
        .o_valid(valid), .o_sel(sel), .o_row(row), .o_col(col), .o_addr(addr),
        .o_last(last), .o_done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         r;
        int         c;
        int         a;
        logic [8:0] s;
        bit         l;
    } desc_t;

    desc_t expq[$];
    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int done_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] model_sel(int r, int c, int h, int w);
        logic [8:0] m = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                m[3*dr+dc] = (r+dr-1 >= 0) && (r+dr-1 < h) && (c+dc-1 >= 0) && (c+dc-1 < w);
        return m;
    endfunction

    task automatic build_model(input int h, input int w, input int s);
        desc_t d;
        expq.delete();
        for (int r = 0; r < h; r += s)
            for (int c = 0; c < w; c += s) begin
                d.r = r; d.c = c; d.a = r*w + c;
                d.s = model_sel(r, c, h, w);
                d.l = (r+s >= h) && (c+s >= w);
                expq.push_back(d);
            end
    endtask

    // Every cycle with o_valid must present exactly the model's next window.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_count++;
            if (valid) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid row=%0d col=%0d addr=%0d", row, col, addr);
                end else begin
                    chk("descriptor", {row, col, addr, sel, last},
                        {6'(expq[0].r), 6'(expq[0].c), 12'(expq[0].a), expq[0].s, expq[0].l});
                    chk("busy_with_valid", busy, 1);
                    if (ready) begin
                        void'(expq.pop_front());
                        accepted++;
                    end
                end
            end
        end
    end

    task automatic run_frame(input int h, input int w, input bit s2, input int stall_at,
                             input int stall_len, input bit start_mid, input int n_exp);
        int cyc = 0;
        int stalled = 0;
        bit pulsed = 0;
        build_model(h, w, s2 ? 2 : 1);
        chk("model_count", expq.size(), n_exp);
        done_count = 0;
        accepted = 0;
        @(posedge clk); #1;
        start = 1; height = 7'(h); width = 7'(w); stride2 = s2; ready = 1;
        @(posedge clk); #1;
        start = 0; height = 7'd5; width = 7'd9; stride2 = ~s2;
        while (done_count == 0 && cyc < 2000) begin
            if (accepted == stall_at && stalled < stall_len) begin
                ready = 0; stalled++;
            end else ready = 1;
            if (start_mid && accepted == 3 && !pulsed) begin
                start = 1; height = 7'd2; width = 7'd2; pulsed = 1;
            end else start = 0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 0; ready = 1;
        chk("frame_timeout", (done_count > 0), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_count, 1);
        chk("windows_left", expq.size(), 0);
        chk("windows_accepted", accepted, n_exp);
        chk("busy_after_frame", busy, 0);
    endtask

    int a5[9] = '{0, 2, 4, 10, 12, 14, 20, 22, 24};

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, valid, sel, row, col, addr, last, done}, 0);
        rst_n = 1;

        // Hand-computed expectations that pin the model.
        build_model(3, 3, 1);
        chk("m3_sel00", expq[0].s, 9'h1B0);
        chk("m3_sel11", expq[4].s, 9'h1FF);
        chk("m3_sel22", expq[8].s, 9'h01B);
        chk("m3_last", expq[8].l, 1);
        build_model(5, 5, 2);
        for (int i = 0; i < 9; i++) chk("m5_addr", expq[i].a, a5[i]);
        chk("m5_sel44", expq[8].s, 9'h01B);
        build_model(1, 1, 1);
        chk("m1_sel", expq[0].s, 9'h010);
        chk("m1_last", expq[0].l, 1);

        run_frame(3, 3, 0, -1, 0, 0, 9);
        run_frame(5, 5, 1, -1, 0, 0, 9);
        run_frame(4, 4, 0, 5, 3, 0, 16);
        run_frame(1, 1, 0, -1, 0, 0, 1);
        run_frame(3, 0, 0, -1, 0, 0, 0);
        run_frame(6, 7, 0, -1, 0, 1, 42);
        run_frame(7, 6, 1, 2, 2, 0, 12);

        // Reset in the middle of an 8x8 frame.
        build_model(8, 8, 1);
        accepted = 0; done_count = 0;
        @(posedge clk); #1;
        start = 1; height = 7'd8; width = 7'd8; stride2 = 0; ready = 1;
        @(posedge clk); #1;
        start = 0;
        cyc = 0;
        while (accepted < 10 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midframe_progress", (accepted >= 10), 1);
        rst_n = 0;
        @(posedge clk); #1;
        chk("midframe_reset_outputs", {busy, valid, sel, row, col, addr, last, done}, 0);
        expq.delete();
        rst_n = 1;
        done_count = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_count, 0);
        chk("idle_after_reset", {busy, valid}, 0);
        run_frame(8, 8, 0, -1, 0, 0, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pad_window_scanner.md
PAD_WINDOW_SCANNER -- requirements
Module: pad_window_scanner

Interface
REQ-001 SHALL have port i_clk, input, 1: sole clock, all logic on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port i_start, input, 1: start-frame pulse; sampled only in IDLE.
REQ-004 SHALL have port i_height, input, 7: feature-map rows, 0..64; latched on accepted start.
REQ-005 SHALL have port i_width, input, 7: feature-map columns, 0..64; latched on accepted start.
REQ-006 SHALL have port i_stride2, input, 1: 1 = stride 2, 0 = stride 1; latched on accepted start.
REQ-007 SHALL have port o_busy, output, 1: high in RUN and DONE.
REQ-008 SHALL have port o_valid, output, 1: window descriptor valid.
REQ-009 SHALL have port i_ready, input, 1: consumer accepts descriptor.
REQ-010 SHALL have port o_sel, output, 9: 3x3 padding mask, 1 = neighbour in bounds; drives the downstream zero-padding select.
REQ-011 SHALL have ports o_row and o_col, outputs, 6 each: window centre coordinates.
REQ-012 SHALL have port o_addr, output, 12: centre linear address, row*W + col.
REQ-013 SHALL have port o_last, output, 1: current descriptor is the final window of the frame.
REQ-014 SHALL have port o_done, output, 1: one-cycle pulse after the final handshake.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 IDLE with i_start=1 and nonzero H and W SHALL latch the configuration, set r=c=0, addr=0, and enter RUN; o_valid SHALL rise on the next cycle.
REQ-017 IDLE with i_start=1 and H=0 or W=0 SHALL enter DONE directly; no o_valid SHALL be asserted.
REQ-018 i_start outside IDLE SHALL be ignored.
REQ-019 In RUN, o_valid SHALL be 1, and o_sel/o_row/o_col/o_addr/o_last SHALL be registered and held stable while o_valid=1 and i_ready=0.
REQ-020 A handshake (o_valid & i_ready) SHALL advance the scan with step s (s=2 if stride2, else 1): if c+s<W, then c+=s and addr+=s; else c=0, r+=s, and addr = rowbase + s*W, where rowbase tracks r*W; no multiplier SHALL be used.
REQ-021 o_last SHALL be 1 when c+s>=W and r+s>=H.
REQ-022 A handshake with o_last=1 SHALL move the FSM to DONE and drop o_valid in the same cycle.
REQ-023 DONE SHALL assert o_done for exactly one cycle and then return to IDLE.
REQ-024 Bit k = 3*dr+dc of o_sel (dr,dc in 0..2) SHALL be 1 iff neighbour (r+dr-1, c+dc-1) lies in [0,H-1] x [0,W-1]; bit 4 is therefore always 1.
REQ-025 Window count per frame SHALL be ceil(H/s)*ceil(W/s).

Reset
REQ-026 While i_rst_n=0 at a clock edge, FSM SHALL go to IDLE and every output SHALL be 0, including o_sel, o_addr and o_done.
REQ-027 Reset during RUN SHALL abort the frame with no o_done pulse; a following i_start SHALL begin a fresh frame from (0,0).

Structure
REQ-028 A shared package SHALL hold DATA_W=10, WIN_TAPS=9, MAX_DIM=64, ADDR_W=12, and the FSM state type.
REQ-029 Border-mask generation SHALL be one combinational sub-module, pad_mask_calc, with inputs r, c, H, W and output sel[8:0].
REQ-030 The RTL SHALL be synthesizable with no latches.

Verification
REQ-031 3x3, stride 1, i_ready=1 -> 9 windows; (0,0) sel=0x1B0, (1,1) sel=0x1FF, (2,2) sel=0x01B with o_last=1; o_done pulses once.
REQ-032 5x5, stride 2 -> o_addr sequence 0,2,4,10,12,14,20,22,24; sel at (4,4)=0x01B.
REQ-033 4x4, stride 1, i_ready low for 3 cycles at window 5 -> outputs held constant; 16 windows total, none lost or duplicated.
REQ-034 1x1 -> single window, sel=0x010, o_last=1; W=0 -> o_done pulse with no o_valid.
REQ-035 Reset asserted mid-frame on 8x8 -> all outputs 0 next cycle, no o_done; restart -> first descriptor (0,0), addr 0.
REQ-036 i_start pulsed during RUN -> no effect on sequence or window count.
